// File: rtl/pll_lock_sequencer.sv
// Brings up the 25 MHz pixel PLL from the 12 MHz reference: pulses RESETB, debounces LOCK,
// then releases core and video resets in order; retries on timeout, re-sequences on lock loss.
module pll_lock_sequencer #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 120000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int VIDEO_DELAY_CYCLES  = 64,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       clk_12MHz,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       core_rst_n,
  output logic       video_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [3:0] lost_count
);

  localparam int M0 = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int M1 = (M0 > LOCK_STABLE_CYCLES) ? M0 : LOCK_STABLE_CYCLES;
  localparam int MAXP = (M1 > VIDEO_DELAY_CYCLES) ? M1 : VIDEO_DELAY_CYCLES;
  localparam int CNT_W = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN_CORE  = 3'd3,
    RUN_ALL   = 3'd4,
    FAULT     = 3'd5
  } state_e;

  state_e             st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         retry_q, retry_d;
  logic [3:0]         lost_q, lost_d;
  logic [1:0]         sync_q, sync_d;
  logic               pll_resetb_q, pll_resetb_d;
  logic               core_rst_n_q, core_rst_n_d;
  logic               video_rst_n_q, video_rst_n_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               lock_s;

  // pll_lock is asynchronous to clk_12MHz; only the second stage is ever used
  assign lock_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], pll_lock};
    st_d    = st_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (st_q)
      PLL_RST:
        if (cnt_q == CNT_W'(PLL_RESET_CYCLES - 1)) st_d = WAIT_LOCK;
      WAIT_LOCK:
        if (lock_s) st_d = STABLE;
        else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_d = (retry_q == 4'hf) ? retry_q : retry_q + 4'd1;
          st_d    = (retry_d == 4'(MAX_RETRIES)) ? FAULT : PLL_RST;
        end
      STABLE:
        if (!lock_s) st_d = WAIT_LOCK;
        else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) st_d = RUN_CORE;
      RUN_CORE, RUN_ALL:
        // loss takes priority over the video-release threshold
        if (!lock_s) begin
          lost_d = (lost_q == 4'hf) ? lost_q : lost_q + 4'd1;
          st_d   = PLL_RST;
        end else if (st_q == RUN_CORE && cnt_q == CNT_W'(VIDEO_DELAY_CYCLES - 1)) begin
          st_d = RUN_ALL;
        end
      FAULT:   st_d = FAULT;
      default: st_d = PLL_RST;
    endcase

    if (st_d != st_q) cnt_d = '0;
    else if (st_q == RUN_ALL || st_q == FAULT) cnt_d = cnt_q;

    // outputs are a function of the state being entered, so they change on the transition edge
    pll_resetb_d  = (st_d == WAIT_LOCK) || (st_d == STABLE) || (st_d == RUN_CORE) || (st_d == RUN_ALL);
    core_rst_n_d  = (st_d == RUN_CORE) || (st_d == RUN_ALL);
    video_rst_n_d = (st_d == RUN_ALL);
    ready_d       = (st_d == RUN_ALL);
    fault_d       = (st_d == FAULT);
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= PLL_RST;
      cnt_q         <= '0;
      retry_q       <= '0;
      lost_q        <= '0;
      sync_q        <= '0;
      pll_resetb_q  <= 1'b0;
      core_rst_n_q  <= 1'b0;
      video_rst_n_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      st_q          <= st_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      lost_q        <= lost_d;
      sync_q        <= sync_d;
      pll_resetb_q  <= pll_resetb_d;
      core_rst_n_q  <= core_rst_n_d;
      video_rst_n_q <= video_rst_n_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign core_rst_n  = core_rst_n_q;
  assign video_rst_n = video_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short parameters; edge counts are hand-derived.
module tb_pll_lock_sequencer;

  logic       clk_12MHz = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_resetb, core_rst_n, video_rst_n, ready, fault;
  logic [3:0] retry_count, lost_count;

  int total = 0;
  int bad   = 0;
  int n;
  int inv_err = 0;
  logic vid_watch = 1'b0;
  logic vid_seen  = 1'b0;

  localparam int SIG_PBR = 0, SIG_CORE = 1, SIG_VID = 2;

  pll_lock_sequencer #(
    .PLL_RESET_CYCLES(4), .LOCK_TIMEOUT_CYCLES(50), .LOCK_STABLE_CYCLES(8),
    .VIDEO_DELAY_CYCLES(6), .MAX_RETRIES(2)
  ) dut (
    .clk_12MHz(clk_12MHz), .rst_n(rst_n), .pll_lock(pll_lock),
    .pll_resetb(pll_resetb), .core_rst_n(core_rst_n), .video_rst_n(video_rst_n),
    .ready(ready), .fault(fault), .retry_count(retry_count), .lost_count(lost_count)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  always @(negedge clk_12MHz) begin
    if (rst_n === 1'b1) begin
      if (video_rst_n && !core_rst_n) inv_err <= inv_err + 1;
      if (core_rst_n && !pll_resetb)  inv_err <= inv_err + 1;
    end
    if (vid_watch && video_rst_n) vid_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic logic sig(input int w);
    case (w)
      SIG_PBR:  return pll_resetb;
      SIG_CORE: return core_rst_n;
      default:  return video_rst_n;
    endcase
  endfunction

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk_12MHz);
      @(negedge clk_12MHz);
    end
  endtask

  // counts edges (from the current negedge) until the signal reaches lvl; bounded
  task automatic wait_lvl(input int w, input logic lvl, output int cnt);
    cnt = 0;
    while (sig(w) !== lvl && cnt < 200) begin
      @(posedge clk_12MHz);
      cnt++;
      @(negedge clk_12MHz);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_lock = 1'b0;
    cyc(2);
    chk("rst_pbr",   pll_resetb, 0);
    chk("rst_core",  core_rst_n, 0);
    chk("rst_vid",   video_rst_n, 0);
    chk("rst_ready", ready, 0);
    chk("rst_fault", fault, 0);
    chk("rst_retry", retry_count, 0);
    chk("rst_lost",  lost_count, 0);

    // nominal bring-up
    rst_n = 1'b1;
    wait_lvl(SIG_PBR, 1'b1, n);  chk("nom_pbr_low_len", n, 4);
    cyc(10);
    pll_lock = 1'b1;
    wait_lvl(SIG_CORE, 1'b1, n); chk("nom_core_lat", n, 11);
    chk("nom_vid_still_low", video_rst_n, 0);
    wait_lvl(SIG_VID, 1'b1, n);  chk("nom_vid_lat", n, 6);
    chk("nom_ready", ready, 1);
    chk("nom_retry", retry_count, 0);
    chk("nom_lost",  lost_count, 0);

    // lock loss in RUN_ALL, then full re-sequence
    pll_lock = 1'b0;
    wait_lvl(SIG_CORE, 1'b0, n); chk("loss_core_lat", n, 3);
    chk("loss_vid",   video_rst_n, 0);
    chk("loss_ready", ready, 0);
    chk("loss_lost",  lost_count, 1);
    chk("loss_pbr",   pll_resetb, 0);
    wait_lvl(SIG_PBR, 1'b1, n);  chk("loss_pbr_len", n, 4);
    pll_lock = 1'b1;
    wait_lvl(SIG_CORE, 1'b1, n); chk("reseq_core_lat", n, 11);
    wait_lvl(SIG_VID, 1'b1, n);  chk("reseq_vid_lat", n, 6);
    chk("reseq_ready", ready, 1);
    chk("reseq_lost",  lost_count, 1);

    // async reset from RUN_ALL, no edge in between
    #1 rst_n = 1'b0; pll_lock = 1'b0;
    #1;
    chk("arst_run_core",  core_rst_n, 0);
    chk("arst_run_vid",   video_rst_n, 0);
    chk("arst_run_ready", ready, 0);
    chk("arst_run_lost",  lost_count, 0);
    chk("arst_run_pbr",   pll_resetb, 0);
    @(negedge clk_12MHz);
    rst_n = 1'b1;

    // debounce restart
    wait_lvl(SIG_PBR, 1'b1, n);  chk("deb_pbr_len", n, 4);
    pll_lock = 1'b1;
    cyc(5);
    pll_lock = 1'b0;
    cyc(2);
    chk("deb_core_low", core_rst_n, 0);
    pll_lock = 1'b1;
    wait_lvl(SIG_CORE, 1'b1, n); chk("deb_core_lat", n, 11);
    chk("deb_retry", retry_count, 0);

    // timeout and fault
    rst_n = 1'b0; pll_lock = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    wait_lvl(SIG_PBR, 1'b1, n);  chk("to_pbr1_len", n, 4);
    wait_lvl(SIG_PBR, 1'b0, n);  chk("to_wait1_len", n, 50);
    chk("to_retry1", retry_count, 1);
    chk("to_fault0", fault, 0);
    wait_lvl(SIG_PBR, 1'b1, n);  chk("to_pbr2_len", n, 4);
    wait_lvl(SIG_PBR, 1'b0, n);  chk("to_wait2_len", n, 50);
    chk("to_fault1", fault, 1);
    chk("to_retry2", retry_count, 2);
    pll_lock = 1'b1;
    cyc(20);
    chk("fault_sticky", fault, 1);
    chk("fault_pbr",    pll_resetb, 0);
    chk("fault_core",   core_rst_n, 0);
    chk("fault_retry",  retry_count, 2);
    #1 rst_n = 1'b0; pll_lock = 1'b0;
    #1;
    chk("arst_fault",       fault, 0);
    chk("arst_fault_retry", retry_count, 0);
    @(negedge clk_12MHz);
    rst_n = 1'b1;

    // lock loss in RUN_CORE, coinciding with the video threshold
    wait_lvl(SIG_PBR, 1'b1, n);  chk("rc_pbr_len", n, 4);
    pll_lock = 1'b1;
    wait_lvl(SIG_CORE, 1'b1, n); chk("rc_core_lat", n, 11);
    vid_watch = 1'b1;
    cyc(3);
    pll_lock = 1'b0;
    wait_lvl(SIG_CORE, 1'b0, n); chk("rc_loss_lat", n, 3);
    chk("rc_lost", lost_count, 1);
    chk("rc_pbr",  pll_resetb, 0);
    cyc(10);
    vid_watch = 1'b0;
    chk("rc_vid_never", vid_seen, 0);

    // async reset during STABLE, between edges
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    wait_lvl(SIG_PBR, 1'b1, n);  chk("st_pbr_len", n, 4);
    pll_lock = 1'b1;
    cyc(5);
    chk("st_pbr_hi",  pll_resetb, 1);
    chk("st_core_lo", core_rst_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_st_pbr",   pll_resetb, 0);
    chk("arst_st_core",  core_rst_n, 0);
    chk("arst_st_fault", fault, 0);
    chk("arst_st_lost",  lost_count, 0);
    pll_lock = 1'b0;
    cyc(2);

    chk("invariants", inv_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
